// File: rtl/gb_camera_capture_if.sv
// gb_camera_capture_if
//   Bundles the three buses of the Game Boy Camera capture block:
//   - CPU register window: ce_cpu, cam_en, cart_addr, cart_wr, cart_di -> cam_do, busy
//   - sensor pixel fetch:  pix_req, pix_x, pix_y <- pix_valid, pix_luma
//   - cart RAM write:      ram_wr, ram_waddr, ram_wdata <- ram_wr_ack
//   slave  = capture block view, master = CPU/sensor/RAM side view.
interface gb_camera_capture_if;
  logic        ce_cpu;
  logic        cam_en;
  logic [15:0] cart_addr;
  logic        cart_wr;
  logic [7:0]  cart_di;
  logic [7:0]  cam_do;
  logic        busy;
  logic        pix_req;
  logic [6:0]  pix_x;
  logic [6:0]  pix_y;
  logic        pix_valid;
  logic [7:0]  pix_luma;
  logic        ram_wr;
  logic [16:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic        ram_wr_ack;

  modport slave (
    input  ce_cpu, cam_en, cart_addr, cart_wr, cart_di, pix_valid, pix_luma, ram_wr_ack,
    output cam_do, busy, pix_req, pix_x, pix_y, ram_wr, ram_waddr, ram_wdata
  );

  modport master (
    output ce_cpu, cam_en, cart_addr, cart_wr, cart_di, pix_valid, pix_luma, ram_wr_ack,
    input  cam_do, busy, pix_req, pix_x, pix_y, ram_wr, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/gb_camera_capture.sv
// gb_camera_capture
//   Game Boy Camera register responder and capture engine. Holds the sensor
//   register file (0x00-0x35), waits the programmed exposure, fetches 128x112
//   luma samples, dithers them through the 4x4 matrix of 3 thresholds and
//   writes 2bpp tile data into cart RAM starting at IMG_BASE.
// Ports:
//   clk_sys  - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - gb_camera_capture_if.slave (CPU window, pixel fetch, RAM write)
module gb_camera_capture #(
  parameter int          EXP_SHIFT = 4,
  parameter logic [12:0] IMG_BASE  = 13'h0100
) (
  input  logic clk_sys,
  input  logic reset_n,
  gb_camera_capture_if.slave bus
);
  localparam int CW = 16 + EXP_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE, S_EXPOSE, S_REQ, S_SHIFT, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_regs [0:53];
  logic          r_busy;
  logic          r_pix_req;
  logic          r_ram_wr;
  logic [6:0]    r_x;
  logic [6:0]    r_y;
  logic [12:0]   r_waddr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic [7:0]    r_luma;
  logic [CW-1:0] r_cnt;

  logic          w_sel, w_we, w_wr0, w_start, w_abort, w_last;
  logic [6:0]    w_idx;
  logic [5:0]    w_ti;
  logic [7:0]    w_t0, w_t1, w_t2;
  logic [1:0]    w_c;
  logic [7:0]    w_lo_n, w_hi_n;
  logic [12:0]   w_addr;
  logic [CW-1:0] w_exp;
  logic          w_unused;

  assign w_sel   = bus.cam_en && (bus.cart_addr[15:13] == 3'b101);
  assign w_idx   = bus.cart_addr[6:0];
  assign w_we    = bus.ce_cpu && bus.cart_wr && w_sel;
  assign w_wr0   = w_we && (w_idx == 7'd0);
  assign w_start = w_wr0 && bus.cart_di[0] && (r_state == S_IDLE);
  assign w_abort = w_wr0 && !bus.cart_di[0] && (r_state != S_IDLE);
  assign w_unused = ^bus.cart_addr[12:7];

  assign bus.cam_do    = (w_sel && w_idx == 7'd0) ? {5'b0, r_regs[0][2:1], r_busy} : 8'h00;
  assign bus.busy      = r_busy;
  assign bus.pix_req   = r_pix_req;
  assign bus.pix_x     = r_x;
  assign bus.pix_y     = r_y;
  assign bus.ram_wr    = r_ram_wr;
  assign bus.ram_waddr = {4'b0, r_waddr};
  assign bus.ram_wdata = r_wdata;

  // Matrix entry for this pixel: three consecutive bytes starting at 0x06.
  assign w_ti = {2'b0, r_y[1:0], r_x[1:0]} * 6'd3;
  assign w_t0 = r_regs[w_ti + 6'd6];
  assign w_t1 = r_regs[w_ti + 6'd7];
  assign w_t2 = r_regs[w_ti + 6'd8];

  always_comb begin
    w_c = 2'd3;
    if (r_luma >= w_t2)      w_c = 2'd0;
    else if (r_luma >= w_t1) w_c = 2'd1;
    else if (r_luma >= w_t0) w_c = 2'd2;
  end

  assign w_lo_n = {r_lo[6:0], w_c[0]};
  assign w_hi_n = {r_hi[6:0], w_c[1]};
  // tile = {y[6:3], x[6:3]}; 16 bytes per tile, 2 per tile row
  assign w_addr = IMG_BASE + {1'b0, r_y[6:3], r_x[6:3], 4'b0} + {9'b0, r_y[2:0], 1'b0};
  assign w_last = (r_x == 7'd127) && (r_y == 7'd111);
  assign w_exp  = CW'({r_regs[2], r_regs[3]}) << EXP_SHIFT;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 54; i++) r_regs[i] <= 8'h00;
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_pix_req <= 1'b0;
      r_ram_wr  <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_luma    <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_we && w_idx < 7'd54) r_regs[w_idx[5:0]] <= bus.cart_di;

      case (r_state)
        S_IDLE: if (w_start) begin
          r_state <= S_EXPOSE;
          r_busy  <= 1'b1;
          r_cnt   <= w_exp;
          r_x     <= '0;
          r_y     <= '0;
        end
        S_EXPOSE: begin
          if (r_cnt == '0) begin
            r_state   <= S_REQ;
            r_pix_req <= 1'b1;
          end else if (bus.ce_cpu) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_REQ: if (bus.pix_valid) begin
          r_luma    <= bus.pix_luma;
          r_pix_req <= 1'b0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          r_lo <= w_lo_n;
          r_hi <= w_hi_n;
          if (r_x[2:0] == 3'd7) begin
            r_state  <= S_WR_LO;
            r_ram_wr <= 1'b1;
            r_waddr  <= w_addr;
            r_wdata  <= w_lo_n;
          end else begin
            r_x       <= r_x + 7'd1;
            r_state   <= S_REQ;
            r_pix_req <= 1'b1;
          end
        end
        S_WR_LO: if (bus.ram_wr_ack) begin
          r_waddr <= r_waddr + 13'd1;
          r_wdata <= r_hi;
          r_state <= S_WR_HI;
        end
        S_WR_HI: if (bus.ram_wr_ack) begin
          r_ram_wr <= 1'b0;
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            if (r_x == 7'd127) begin
              r_x <= '0;
              r_y <= r_y + 7'd1;
            end else begin
              r_x <= r_x + 7'd1;
            end
            r_state   <= S_REQ;
            r_pix_req <= 1'b1;
          end
        end
        S_DONE: begin
          r_regs[0][0] <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // A CPU write clearing the trigger stops everything on the next edge.
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_pix_req <= 1'b0;
        r_ram_wr  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gb_camera_capture.sv
`timescale 1ns/1ps
module tb_gb_camera_capture;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gb_camera_capture_if bus();
  gb_camera_capture #(.EXP_SHIFT(4), .IMG_BASE(13'h0100)) dut (
    .clk_sys(clk), .reset_n(rst_n), .bus(bus)
  );

  typedef struct packed { logic [16:0] a; logic [7:0] d; } wr_t;

  int total = 0, bad = 0;
  wr_t exp_q[$];
  logic [7:0] tb_th [0:53];
  logic [7:0] ram_img [0:8191];
  int ce_div = 1, ce_ph = 0;
  int lmode = 0;
  bit stall_en = 0, pix_hold = 0;
  int n_wr = 0;
  int first_addr = -1, last_addr = -1;
  logic last_busy;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int lum(input int x, input int y);
    if (lmode == 0) return 8'h90;
    return (x * 2) & 255;
  endfunction

  // Reference dither: color from the three thresholds of the matrix cell.
  function automatic int color(input int l, input int x, input int y);
    int i;
    i = ((y % 4) * 4 + (x % 4)) * 3;
    if (l >= tb_th[8 + i]) return 0;
    if (l >= tb_th[7 + i]) return 1;
    if (l >= tb_th[6 + i]) return 2;
    return 3;
  endfunction

  function automatic int plane_byte(input int y, input int xb, input int pl);
    int b;
    b = 0;
    for (int k = 0; k < 8; k++)
      b |= ((color(lum(xb * 8 + k, y), xb * 8 + k, y) >> pl) & 1) << (7 - k);
    return b;
  endfunction

  task automatic build_expected();
    int a;
    exp_q.delete();
    for (int y = 0; y < 112; y++)
      for (int xb = 0; xb < 16; xb++) begin
        a = 'h100 + ((y / 8) * 16 + xb) * 16 + (y % 8) * 2;
        exp_q.push_back('{a: 17'(a),     d: 8'(plane_byte(y, xb, 0))});
        exp_q.push_back('{a: 17'(a + 1), d: 8'(plane_byte(y, xb, 1))});
      end
  endtask

  function automatic int pick_delay();
    if (!stall_en) return 0;
    if ($urandom_range(0, 3) != 0) return 0;
    return $urandom_range(1, 20);
  endfunction

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic en = 1'b1);
    bus.cam_en = en; bus.cart_addr = a; bus.cart_di = d; bus.cart_wr = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (bus.ce_cpu) break;
    end
    if (en && a[15:13] == 3'b101 && a[6:0] < 7'd54) tb_th[a[5:0]] = d;
    #1 bus.cart_wr = 1'b0; bus.cam_en = 1'b1; bus.cart_addr = 16'hA000;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic en, output logic [7:0] d);
    bus.cam_en = en; bus.cart_wr = 1'b0; bus.cart_addr = a;
    #1 d = bus.cam_do;
    bus.cam_en = 1'b1; bus.cart_addr = 16'hA000;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!bus.busy) break;
    end
    if (k == budget) begin
      total++; bad++;
      $display("FAIL %s: timeout busy=%0d want 0", nm, bus.busy);
    end
  endtask

  task automatic wait_writes(input int n, input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (n_wr >= n) break;
    end
    if (k == budget) begin
      total++; bad++;
      $display("FAIL %s: timeout writes=%0d want %0d", nm, n_wr, n);
    end
  endtask

  // CPU clock enable, changes on the falling edge.
  initial begin
    bus.ce_cpu = 1'b1;
    forever begin
      @(negedge clk);
      ce_ph = (ce_ph + 1) % ce_div;
      bus.ce_cpu = (ce_ph == 0);
    end
  end

  // Sensor model.
  initial begin
    int px, py, d;
    bit stable, alive;
    bus.pix_valid = 1'b0; bus.pix_luma = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.pix_req && !pix_hold) begin
        px = bus.pix_x; py = bus.pix_y; stable = 1; alive = 1;
        d = pick_delay();
        for (int k = 0; k < d; k++) begin
          @(posedge clk); #1;
          if (!bus.pix_req) begin alive = 0; break; end
          if (bus.pix_x != 7'(px) || bus.pix_y != 7'(py)) stable = 0;
        end
        if (alive) begin
          if (d > 0) chk("pix_xy_stable", stable, 1);
          bus.pix_luma = 8'(lum(px, py));
          bus.pix_valid = 1'b1;
          @(posedge clk); #1 bus.pix_valid = 1'b0;
        end
      end
    end
  end

  // RAM model.
  initial begin
    logic [16:0] a; logic [7:0] dd;
    int d;
    bit stable, alive;
    bus.ram_wr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.ram_wr) begin
        a = bus.ram_waddr; dd = bus.ram_wdata; stable = 1; alive = 1;
        d = pick_delay();
        for (int k = 0; k < d; k++) begin
          @(posedge clk); #1;
          if (!bus.ram_wr) begin alive = 0; break; end
          if (bus.ram_waddr != a || bus.ram_wdata != dd) stable = 0;
        end
        if (alive) begin
          if (d > 0) chk("ram_wr_stable", stable, 1);
          bus.ram_wr_ack = 1'b1;
          @(posedge clk); #1 bus.ram_wr_ack = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted write is compared with the queue head.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ram_wr && bus.ram_wr_ack) begin
        n_wr++;
        if (first_addr < 0) first_addr = int'(bus.ram_waddr);
        last_addr = int'(bus.ram_waddr);
        last_busy = bus.busy;
        ram_img[bus.ram_waddr[12:0]] = bus.ram_wdata;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h want none", bus.ram_waddr, bus.ram_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.ram_waddr, e.a);
          chk("wr_data", bus.ram_wdata, e.d);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int ticks, nw0, k;
    bit ce_last;
    for (int i = 0; i < 54; i++) tb_th[i] = 8'h00;
    rst_n = 1'b0;
    bus.cam_en = 1'b1; bus.cart_addr = 16'hA000; bus.cart_wr = 1'b0; bus.cart_di = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cam_do", bus.cam_do, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pix_req", bus.pix_req, 0);
    chk("rst_ram_wr", bus.ram_wr, 0);
    chk("rst_waddr", bus.ram_waddr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_pix_xy", {bus.pix_x, bus.pix_y}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Register window
    cpu_write(16'hA001, 8'h5A);
    cpu_read(16'hA001, 1'b1, rd); chk("rd_a001", rd, 0);
    cpu_write(16'hA000, 8'h06);
    cpu_read(16'hA000, 1'b1, rd); chk("rd_a000", rd, 8'h06);
    cpu_write(16'hA040, 8'h01);
    cpu_write(16'hA000, 8'h01, 1'b0);
    cpu_write(16'h8000, 8'h01);
    repeat (3) @(posedge clk); #1;
    cpu_read(16'hA000, 1'b1, rd); chk("rd_a000_unchanged", rd, 8'h06);
    cpu_read(16'hA000, 1'b0, rd); chk("rd_unselected", rd, 0);

    // Full capture, uniform luma
    for (int i = 0; i < 16; i++) begin
      cpu_write(16'(16'hA006 + 3 * i), 8'h40);
      cpu_write(16'(16'hA007 + 3 * i), 8'h80);
      cpu_write(16'(16'hA008 + 3 * i), 8'hC0);
    end
    cpu_write(16'hA002, 8'h00);
    cpu_write(16'hA003, 8'h00);
    lmode = 0; stall_en = 0;
    build_expected();
    n_wr = 0; first_addr = -1;
    cpu_write(16'hA000, 8'h01);
    chk("busy_started", bus.busy, 1);
    wait_idle(60000, "full_capture");
    chk("full_nwr", n_wr, 3584);
    chk("full_queue_left", exp_q.size(), 0);
    chk("full_first_addr", first_addr, 'h100);
    chk("full_last_addr", last_addr, 'hEFF);
    chk("busy_at_last_ack", last_busy, 1);
    cpu_read(16'hA000, 1'b1, rd); chk("reg0_after_done", rd, 0);

    // Dither/address with stalls, one matrix cell randomized
    lmode = 1; stall_en = 1;
    cpu_write(16'hA006 + 42, 8'($urandom));
    cpu_write(16'hA007 + 42, 8'($urandom));
    cpu_write(16'hA008 + 42, 8'($urandom));
    build_expected();
    n_wr = 0; first_addr = -1;
    cpu_write(16'hA000, 8'h01);
    wait_writes(512, 40000, "stall_writes");
    for (k = 0; k < 200; k++) begin
      if (bus.pix_req) break;
      @(posedge clk); #1;
    end
    cpu_write(16'hA000, 8'h00);
    chk("stall_abort_busy", bus.busy, 0);
    chk("stall_abort_req", bus.pix_req, 0);
    chk("stall_abort_wr", bus.ram_wr, 0);
    exp_q.delete();
    nw0 = n_wr;
    chk("tile17_row3_lo", ram_img[13'h216], plane_byte(11, 1, 0));
    chk("tile17_row3_hi", ram_img[13'h217], plane_byte(11, 1, 1));
    stall_en = 0;
    repeat (100) @(posedge clk); #1;
    chk("stall_no_more_wr", n_wr, nw0);

    // Exposure timing, then abort during REQ
    lmode = 0; ce_div = 3; pix_hold = 1;
    cpu_write(16'hA002, 8'h00);
    cpu_write(16'hA003, 8'h10);
    build_expected();
    cpu_write(16'hA000, 8'h01);
    ticks = 0; ce_last = 0;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      ce_last = bus.ce_cpu;
      if (bus.ce_cpu) ticks++;
      #1;
      if (bus.pix_req) break;
    end
    chk("exposure_ticks", ticks, 256 + int'(ce_last));
    chk("req_in_exposure_test", bus.pix_req, 1);
    nw0 = n_wr;
    cpu_write(16'hA000, 8'h00);
    chk("abort_busy", bus.busy, 0);
    chk("abort_req", bus.pix_req, 0);
    chk("abort_wr", bus.ram_wr, 0);
    exp_q.delete();
    ce_div = 1; pix_hold = 0;
    repeat (100) @(posedge clk); #1;
    chk("abort_no_wr", n_wr, nw0);
    chk("abort_stays_idle", bus.pix_req, 0);

    // Asynchronous reset mid-capture
    cpu_write(16'hA003, 8'h00);
    build_expected();
    n_wr = 0;
    cpu_write(16'hA000, 8'h01);
    wait_writes(10, 2000, "reset_pre_writes");
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ram_wr", bus.ram_wr, 0);
    chk("arst_pix_req", bus.pix_req, 0);
    exp_q.delete();
    cpu_read(16'hA000, 1'b1, rd); chk("arst_a000", rd, 0);
    #10 rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
